// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR coder/decoder pair: copy geometry, lane health encoding,
// and a helper that extracts one copy from a triplicated word.
package tmr_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned COPIES = 3;

  typedef enum logic [1:0] {
    LANE_OK      = 2'b00,
    LANE_SUSPECT = 2'b01,
    LANE_FAILED  = 2'b10
  } lane_state_e;

  function automatic logic [DATA_W-1:0] get_copy(input logic [COPIES*DATA_W-1:0] word,
                                                 input int unsigned idx);
    return word[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Health tracker for one copy: counts consecutive mismatches and walks OK/SUSPECT/FAILED.
module tmr_lane_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        mismatch,
  input  logic        fault_clr,
  output lane_state_e state,
  output lane_state_e state_nxt_c
);

  localparam int unsigned MISS_W = 8;

  logic [MISS_W-1:0] miss_q;
  logic [MISS_W-1:0] miss_d;
  lane_state_e       state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= LANE_OK;
      miss_q <= '0;
    end else begin
      state  <= state_d;
      miss_q <= miss_d;
    end
  end

  // Clear wins over any transition; otherwise only valid words move the tracker.
  always_comb begin
    state_d = state;
    miss_d  = miss_q;
    if (fault_clr) begin
      state_d = LANE_OK;
      miss_d  = '0;
    end else if (valid) begin
      if (mismatch) begin
        if (miss_q != '1) miss_d = miss_q + MISS_W'(1);
        case (state)
          LANE_OK:      state_d = LANE_SUSPECT;
          LANE_SUSPECT: if (miss_d >= MISS_W'(FAIL_THRESH)) state_d = LANE_FAILED;
          default:      state_d = state;
        endcase
      end else begin
        miss_d = '0;
        if (state == LANE_SUSPECT) state_d = LANE_OK;
      end
    end
  end

  assign state_nxt_c = state_d;

endmodule

// File: rtl/tmr_decoder.sv
// Receive-side TMR decoder: two-stage majority voter with mismatch flags, a saturating
// corrected-word counter and per-copy fault tracking.
module tmr_decoder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3*DATA_W-1:0] data_in,
  input  logic                in_valid,
  input  logic                cnt_clr,
  input  logic                fault_clr,
  output logic [DATA_W-1:0]   data_out,
  output logic                out_valid,
  output logic                corrected,
  output logic [2:0]          err_lane,
  output logic                multi_lane,
  output logic [CNT_W-1:0]    corr_count,
  output logic [5:0]          lane_state,
  output logic                degraded
);

  import tmr_pkg::*;

  logic [3*DATA_W-1:0] s1_data;
  logic                s1_valid;
  logic [DATA_W-1:0]   copy_c [COPIES];
  logic [DATA_W-1:0]   vote_c;
  logic [COPIES-1:0]   err_c;
  logic [COPIES-1:0]   failed_nxt_c;
  logic                corr_c;
  logic                multi_c;
  logic                degraded_c;
  lane_state_e         lane_st  [COPIES];
  lane_state_e         lane_nxt [COPIES];

  // Stage 1: input capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_data  <= data_in;
      s1_valid <= in_valid;
    end
  end

  assign vote_c = (copy_c[0] & copy_c[1]) | (copy_c[1] & copy_c[2]) | (copy_c[0] & copy_c[2]);

  for (genvar i = 0; i < COPIES; i++) begin : g_lane
    assign copy_c[i]       = s1_data[i*DATA_W +: DATA_W];
    assign err_c[i]        = |(copy_c[i] ^ vote_c);
    assign failed_nxt_c[i] = (lane_nxt[i] == LANE_FAILED);
    assign lane_state[2*i +: 2] = lane_st[i];

    tmr_lane_monitor #(.FAIL_THRESH(FAIL_THRESH)) u_mon (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid       (s1_valid),
      .mismatch    (err_c[i]),
      .fault_clr   (fault_clr),
      .state       (lane_st[i]),
      .state_nxt_c (lane_nxt[i])
    );
  end

  assign corr_c     = |err_c;
  assign multi_c    = (err_c[0] & err_c[1]) | (err_c[1] & err_c[2]) | (err_c[0] & err_c[2]);
  assign degraded_c = (failed_nxt_c[0] & failed_nxt_c[1]) | (failed_nxt_c[1] & failed_nxt_c[2]) |
                      (failed_nxt_c[0] & failed_nxt_c[2]);

  // Stage 2: voted word and flags; payload holds when no valid word is present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      corrected  <= 1'b0;
      err_lane   <= '0;
      multi_lane <= 1'b0;
      corr_count <= '0;
      degraded   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      degraded  <= degraded_c;
      if (s1_valid) begin
        data_out   <= vote_c;
        corrected  <= corr_c;
        err_lane   <= err_c;
        multi_lane <= multi_c;
      end
      if (cnt_clr) begin
        corr_count <= '0;
      end else if (s1_valid && corr_c && (corr_count != '1)) begin
        corr_count <= corr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tmr_decoder.sv
// Randomized scoreboard bench for tmr_decoder with a bit-counting reference model.
module tb_tmr_decoder;

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;
  localparam int          THR   = 4;
  localparam int          CMAX  = 15;

  logic          clk;
  logic          rst_n;
  logic [47:0]   data_in;
  logic          in_valid;
  logic          cnt_clr;
  logic          fault_clr;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          corrected;
  logic [2:0]    err_lane;
  logic          multi_lane;
  logic [CW-1:0] corr_count;
  logic [5:0]    lane_state;
  logic          degraded;

  tmr_decoder #(.DATA_W(DW), .CNT_W(CW), .FAIL_THRESH(THR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .cnt_clr    (cnt_clr),
    .fault_clr  (fault_clr),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .corrected  (corrected),
    .err_lane   (err_lane),
    .multi_lane (multi_lane),
    .corr_count (corr_count),
    .lane_state (lane_state),
    .degraded   (degraded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        corr;
    logic [2:0]  err;
    logic        multi;
    logic [3:0]  cnt;
    logic [5:0]  lanes;
    logic        deg;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  // Reference state: saturating count, per-copy miss run length and health (0 OK, 1 SUSPECT, 2 FAILED).
  int m_cnt;
  int m_miss [3];
  int m_st   [3];
  logic        prev_v;
  logic [47:0] prev_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_miss[i] = 0;
      m_st[i]   = 0;
    end
    sb.delete();
    prev_v = 1'b0;
    prev_w = '0;
  endtask

  // Computes the response to word w reaching the output, with clears that act on the same edge.
  task automatic model_step(input logic v, input logic [47:0] w, input logic cc, input logic fc);
    exp_t        e;
    logic [15:0] c [3];
    logic [15:0] vote;
    int          n;
    int          nfail;
    e = '{default: '0};
    if (v) begin
      for (int unsigned i = 0; i < 3; i++) c[i] = tmr_pkg::get_copy(w, i);
      for (int b = 0; b < 16; b++) begin
        n = 0;
        for (int i = 0; i < 3; i++) if (c[i][b]) n++;
        vote[b] = (n >= 2);
      end
      for (int i = 0; i < 3; i++) e.err[i] = (c[i] != vote);
      e.data  = vote;
      e.corr  = (e.err != 3'b000);
      e.multi = ($countones(e.err) >= 2);
      if (e.corr && m_cnt < CMAX) m_cnt++;
      for (int i = 0; i < 3; i++) begin
        if (e.err[i]) begin
          if (m_miss[i] < 255) m_miss[i]++;
          if (m_st[i] == 0) m_st[i] = 1;
          else if (m_st[i] == 1 && m_miss[i] >= THR) m_st[i] = 2;
        end else begin
          m_miss[i] = 0;
          if (m_st[i] == 1) m_st[i] = 0;
        end
      end
    end
    if (cc) m_cnt = 0;
    if (fc) for (int i = 0; i < 3; i++) begin
      m_st[i]   = 0;
      m_miss[i] = 0;
    end
    if (v) begin
      nfail = 0;
      for (int i = 0; i < 3; i++) begin
        e.lanes[2*i +: 2] = 2'(m_st[i]);
        if (m_st[i] == 2) nfail++;
      end
      e.cnt = 4'(m_cnt);
      e.deg = (nfail >= 2);
      sb.push_back(e);
    end
  endtask

  // One input cycle; cc/fc apply together with the word driven on the previous cycle.
  task automatic cycle(input logic v, input logic [47:0] w, input logic cc, input logic fc);
    @(negedge clk);
    in_valid  = v;
    data_in   = w;
    cnt_clr   = cc;
    fault_clr = fc;
    model_step(prev_v, prev_w, cc, fc);
    prev_v = v;
    prev_w = w;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_flags"}, {28'd0, corrected, err_lane}, 32'd0);
    chk({tag, "_multi"}, 32'(multi_lane), 32'd0);
    chk({tag, "_corr_count"}, 32'(corr_count), 32'd0);
    chk({tag, "_lane_state"}, 32'(lane_state), 32'd0);
    chk({tag, "_degraded"}, 32'(degraded), 32'd0);
  endtask

  function automatic logic [47:0] trip(input logic [15:0] c2, input logic [15:0] c1,
                                       input logic [15:0] c0);
    return {c2, c1, c0};
  endfunction

  function automatic logic [47:0] rand_word();
    logic [15:0] b;
    logic [15:0] m1;
    logic [15:0] m2;
    int          mode;
    b    = 16'($urandom);
    m1   = 16'($urandom) | 16'h0001;
    m2   = 16'($urandom) & ~m1;
    mode = int'($urandom_range(0, 6));
    case (mode)
      1:       return trip(b, b, b ^ m1);
      2:       return trip(b, b ^ m1, b);
      3:       return trip(b ^ m1, b, b);
      4:       return trip(b, b ^ m2, b ^ m1);
      5:       return {16'($urandom), 16'($urandom), 16'($urandom)};
      default: return trip(b, b, b);
    endcase
  endfunction

  // Monitor: exactly one expected entry is due whenever out_valid should be high.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_valid", 32'(out_valid), 32'd1);
        if (out_valid) begin
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("corrected", 32'(corrected), 32'(e.corr));
          chk("err_lane", 32'(err_lane), 32'(e.err));
          chk("multi_lane", 32'(multi_lane), 32'(e.multi));
          chk("corr_count", 32'(corr_count), 32'(e.cnt));
          chk("lane_state", 32'(lane_state), 32'(e.lanes));
          chk("degraded", 32'(degraded), 32'(e.deg));
        end
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    cnt_clr   = 1'b0;
    fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Directed: clean, single flip, two copies wrong in different bits.
    cycle(1'b1, trip(16'hA5C3, 16'hA5C3, 16'hA5C3), 1'b0, 1'b0);
    cycle(1'b1, trip(16'hA5C3, 16'hA5C2, 16'hA5C3), 1'b0, 1'b0);
    cycle(1'b1, trip(16'h0000, 16'h0002, 16'h0001), 1'b0, 1'b0);
    // Persistent copy2 fault, then a match, then fault_clr.
    repeat (4) cycle(1'b1, trip(16'hFFFF, 16'h1234, 16'h1234), 1'b0, 1'b0);
    cycle(1'b1, trip(16'h1234, 16'h1234, 16'h1234), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    // Copy0 and copy2 both failing in disjoint bits -> degraded.
    repeat (5) cycle(1'b1, trip(16'h1334, 16'h1234, 16'h1235), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    // Counter saturation, then a clear coinciding with a corrected word.
    repeat (20) cycle(1'b1, trip(16'h5555, 16'h5555, 16'h5554), 1'b0, 1'b0);
    cycle(1'b1, trip(16'h5555, 16'h5555, 16'h5554), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Random traffic with occasional clears.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_word(),
            1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 30) == 0));
    end

    // Reset with two words in flight: nothing stale may emerge.
    cycle(1'b1, rand_word(), 1'b0, 1'b0);
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    data_in   = rand_word();
    cnt_clr   = 1'b0;
    fault_clr = 1'b0;
    model_reset();
    @(negedge clk);
    chk_idle_zero("midreset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_idle_zero("postreset");
    for (int k = 0; k < 60; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'b0, 1'($urandom_range(0, 30) == 0));
    end

    repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
